// File: rtl/jpeg_bitstream_aligner.sv
// Entropy-coded segment aligner: strips 0xFF00 stuffing, detects markers and presents an
// LSB-first 16-bit lookahead window. Optional counters are enabled by JPEG_BITSTREAM_STATS_EN.
module jpeg_bitstream_aligner #(
  parameter int unsigned BUF_W = 64,
  parameter int unsigned CNT_W = $clog2(BUF_W + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             flush,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  output logic             byte_ready,
  output logic [15:0]      window,
  output logic             window_valid,
  output logic [CNT_W-1:0] bit_count,
  input  logic             consume_valid,
  input  logic [4:0]       consume_len,
  output logic             marker_detected,
  output logic [7:0]       marker_code,
  output logic             underflow_err
`ifdef JPEG_BITSTREAM_STATS_EN
  ,
  output logic [15:0]      stuff_count,
  output logic [31:0]      bits_consumed
`endif
);

  typedef enum logic [1:0] {StNormal, StSawFf, StMarker} state_e;

  localparam logic [CNT_W-1:0] FillLimit = CNT_W'(BUF_W - 8);
  localparam logic [CNT_W-1:0] WinBits   = CNT_W'(16);

  state_e           state_q;
  logic [BUF_W-1:0] buf_q, buf_d, shifted, mask, ins;
  logic [CNT_W-1:0] cnt_q, cnt_d, base, len_ext;
  logic             accept, consume_ok, consume_bad, do_append;
  logic [7:0]       app_byte, rev;

  always_comb begin
    byte_ready  = (state_q != StMarker) && (cnt_q <= FillLimit);
    accept      = byte_valid && byte_ready;
    len_ext     = CNT_W'(consume_len);
    consume_ok  = consume_valid && (len_ext <= cnt_q);
    consume_bad = consume_valid && (len_ext > cnt_q);

    do_append = 1'b0;
    app_byte  = byte_in;
    if (accept) begin
      case (state_q)
        StNormal: do_append = (byte_in != 8'hFF);
        StSawFf: begin
          do_append = (byte_in == 8'h00);
          app_byte  = 8'hFF;
        end
        default: do_append = 1'b0;
      endcase
    end

    // Consume happens first; the new byte lands just above the surviving bits.
    base    = consume_ok ? (cnt_q - len_ext) : cnt_q;
    shifted = consume_ok ? (buf_q >> consume_len) : buf_q;
    for (int i = 0; i < 8; i++) rev[i] = app_byte[7-i];
    mask  = {{(BUF_W-8){1'b0}}, 8'hFF} << base;
    ins   = {{(BUF_W-8){1'b0}}, rev} << base;
    buf_d = do_append ? ((shifted & ~mask) | ins) : shifted;
    cnt_d = do_append ? (base + CNT_W'(8)) : base;
  end

  // Unbuffered window positions read 0 normally, 1 (JPEG fill) once a marker has ended the data.
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      window[i] = (CNT_W'(i) < cnt_q) ? buf_q[i] : (state_q == StMarker);
    end
    window_valid = (cnt_q >= WinBits) || ((state_q == StMarker) && (cnt_q != '0));
    bit_count    = cnt_q;
  end

`ifdef JPEG_BITSTREAM_STATS_EN
  logic [32:0] cons_sum;
  always_comb cons_sum = {1'b0, bits_consumed} + 33'(consume_len);
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= StNormal;
      buf_q           <= '0;
      cnt_q           <= '0;
      marker_detected <= 1'b0;
      marker_code     <= 8'h00;
      underflow_err   <= 1'b0;
`ifdef JPEG_BITSTREAM_STATS_EN
      stuff_count     <= '0;
      bits_consumed   <= '0;
`endif
    end else if (flush) begin
      state_q         <= StNormal;
      buf_q           <= '0;
      cnt_q           <= '0;
      marker_detected <= 1'b0;
      marker_code     <= 8'h00;
      underflow_err   <= 1'b0;
`ifdef JPEG_BITSTREAM_STATS_EN
      stuff_count     <= '0;
      bits_consumed   <= '0;
`endif
    end else begin
      buf_q <= buf_d;
      cnt_q <= cnt_d;
      if (consume_bad) underflow_err <= 1'b1;
      if (accept) begin
        case (state_q)
          StNormal: if (byte_in == 8'hFF) state_q <= StSawFf;
          StSawFf: begin
            if (byte_in == 8'h00) begin
              state_q <= StNormal;
            end else begin
              marker_code     <= byte_in;
              marker_detected <= 1'b1;
              state_q         <= StMarker;
            end
          end
          default: state_q <= state_q;
        endcase
      end
`ifdef JPEG_BITSTREAM_STATS_EN
      if (accept && (state_q == StSawFf) && (byte_in == 8'h00) && (stuff_count != 16'hFFFF)) begin
        stuff_count <= stuff_count + 16'd1;
      end
      if (consume_ok) bits_consumed <= cons_sum[32] ? 32'hFFFF_FFFF : cons_sum[31:0];
`endif
    end
  end

endmodule

// File: tb/tb_jpeg_bitstream_aligner.sv
// Bench for jpeg_bitstream_aligner: bit-queue reference model checked every cycle, plus
// hand-computed directed expectations. Stats checks follow JPEG_BITSTREAM_STATS_EN.
module tb_jpeg_bitstream_aligner;
  localparam int BUF_W = 64;
  localparam int CNT_W = 7;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             flush = 1'b0;
  logic [7:0]       byte_in = 8'h00;
  logic             byte_valid = 1'b0;
  logic             byte_ready;
  logic [15:0]      window;
  logic             window_valid;
  logic [CNT_W-1:0] bit_count;
  logic             consume_valid = 1'b0;
  logic [4:0]       consume_len = 5'd0;
  logic             marker_detected;
  logic [7:0]       marker_code;
  logic             underflow_err;
`ifdef JPEG_BITSTREAM_STATS_EN
  logic [15:0]      stuff_count;
  logic [31:0]      bits_consumed;
`endif

  jpeg_bitstream_aligner #(.BUF_W(BUF_W), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .window(window), .window_valid(window_valid), .bit_count(bit_count),
    .consume_valid(consume_valid), .consume_len(consume_len),
    .marker_detected(marker_detected), .marker_code(marker_code),
    .underflow_err(underflow_err)
`ifdef JPEG_BITSTREAM_STATS_EN
    , .stuff_count(stuff_count), .bits_consumed(bits_consumed)
`endif
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the destuffed stream as a plain queue of bits, oldest first.
  bit       mq[$];
  bit       m_ff, m_mk, m_uf;
  bit [7:0] m_code;
  int       m_stuff;
  longint   m_cons;

  function automatic void m_reset();
    mq.delete();
    m_ff = 0; m_mk = 0; m_uf = 0; m_code = 8'h00; m_stuff = 0; m_cons = 0;
  endfunction

  function automatic void m_push(input logic [7:0] b);
    for (int k = 7; k >= 0; k--) mq.push_back(b[k]);
  endfunction

  function automatic void m_step();
    bit ready;
    if (flush) begin
      m_reset();
      return;
    end
    ready = !m_mk && (mq.size() <= BUF_W - 8);
    if (consume_valid) begin
      if (int'(consume_len) <= mq.size()) begin
        for (int k = 0; k < int'(consume_len); k++) void'(mq.pop_front());
        m_cons = m_cons + consume_len;
        if (m_cons > 64'hFFFF_FFFF) m_cons = 64'hFFFF_FFFF;
      end else begin
        m_uf = 1;
      end
    end
    if (byte_valid && ready) begin
      if (m_ff) begin
        m_ff = 0;
        if (byte_in == 8'h00) begin
          m_push(8'hFF);
          if (m_stuff < 65535) m_stuff++;
        end else begin
          m_mk = 1;
          m_code = byte_in;
        end
      end else if (byte_in == 8'hFF) begin
        m_ff = 1;
      end else begin
        m_push(byte_in);
      end
    end
  endfunction

  function automatic logic [15:0] m_window();
    logic [15:0] w;
    for (int i = 0; i < 16; i++) w[i] = (i < mq.size()) ? mq[i] : m_mk;
    return w;
  endfunction

  initial m_reset();

  always @(negedge clock) begin
    if (!reset_n) m_reset();
    chk("window", 32'(window), 32'(m_window()));
    chk("window_valid", 32'(window_valid), 32'((mq.size() >= 16) || (m_mk && mq.size() > 0)));
    chk("bit_count", 32'(bit_count), 32'(mq.size()));
    chk("byte_ready", 32'(byte_ready), 32'(!m_mk && (mq.size() <= BUF_W - 8)));
    chk("marker_detected", 32'(marker_detected), 32'(m_mk));
    chk("marker_code", 32'(marker_code), 32'(m_code));
    chk("underflow_err", 32'(underflow_err), 32'(m_uf));
`ifdef JPEG_BITSTREAM_STATS_EN
    chk("stuff_count", 32'(stuff_count), 32'(m_stuff));
    chk("bits_consumed", bits_consumed, 32'(m_cons));
`endif
    if (reset_n) m_step();
  end

  task automatic cycle(input logic bv, input logic [7:0] b, input logic cv,
                       input logic [4:0] cl, input logic fl);
    byte_valid = bv; byte_in = b; consume_valid = cv; consume_len = cl; flush = fl;
    @(posedge clock);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".bit_count"}, 32'(bit_count), 0);
    chk({tag, ".window"}, 32'(window), 0);
    chk({tag, ".window_valid"}, 32'(window_valid), 0);
    chk({tag, ".byte_ready"}, 32'(byte_ready), 1);
    chk({tag, ".marker_detected"}, 32'(marker_detected), 0);
    chk({tag, ".marker_code"}, 32'(marker_code), 0);
    chk({tag, ".underflow_err"}, 32'(underflow_err), 0);
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1;
    chk_reset_vals("in_reset");
    reset_n = 1'b1;
    #1;
    chk_reset_vals("post_reset");

    // A5, 3C then a zero-length consume
    cycle(1, 8'hA5, 0, 0, 0);
    cycle(1, 8'h3C, 0, 0, 0);
    cycle(0, 8'h00, 1, 0, 0);
    chk("t1.bit_count", 32'(bit_count), 16);
    chk("t1.window_valid", 32'(window_valid), 1);
    chk("t1.window", 32'(window), 32'h3CA5);

    // Stuffed FF00 then 0x12
    cycle(0, 8'h00, 0, 0, 1);
    cycle(1, 8'hFF, 0, 0, 0);
    cycle(1, 8'h00, 0, 0, 0);
    cycle(1, 8'h12, 0, 0, 0);
    chk("t2.bit_count", 32'(bit_count), 16);
    chk("t2.window", 32'(window), 32'h48FF);
`ifdef JPEG_BITSTREAM_STATS_EN
    chk("t2.stuff_count", 32'(stuff_count), 1);
`endif

    // 24 bits buffered, consume 5 while appending 0x80
    cycle(0, 8'h00, 0, 0, 1);
    cycle(1, 8'h11, 0, 0, 0);
    cycle(1, 8'h22, 0, 0, 0);
    cycle(1, 8'h33, 0, 0, 0);
    cycle(1, 8'h80, 1, 5, 0);
    chk("t3.bit_count", 32'(bit_count), 27);
    cycle(0, 8'h00, 1, 16, 0);
    chk("t3.bit_count2", 32'(bit_count), 11);
    chk("t3.window", 32'(window), 32'h000E);

    // Marker D9 after C0
    cycle(0, 8'h00, 0, 0, 1);
    cycle(1, 8'hC0, 0, 0, 0);
    cycle(1, 8'hFF, 0, 0, 0);
    cycle(1, 8'hD9, 0, 0, 0);
    chk("t4.marker_detected", 32'(marker_detected), 1);
    chk("t4.marker_code", 32'(marker_code), 32'hD9);
    chk("t4.byte_ready", 32'(byte_ready), 0);
    chk("t4.bit_count", 32'(bit_count), 8);
    chk("t4.window", 32'(window), 32'hFF03);
    chk("t4.window_valid", 32'(window_valid), 1);

    // Underflow: 10 bits buffered, ask for 12
    cycle(0, 8'h00, 0, 0, 1);
    cycle(1, 8'h11, 0, 0, 0);
    cycle(1, 8'h22, 0, 0, 0);
    cycle(0, 8'h00, 1, 6, 0);
    chk("t5.bit_count", 32'(bit_count), 10);
    cycle(0, 8'h00, 1, 12, 0);
    chk("t5.bit_count2", 32'(bit_count), 10);
    chk("t5.underflow_err", 32'(underflow_err), 1);
    cycle(0, 8'h00, 0, 0, 0);
    chk("t5.sticky", 32'(underflow_err), 1);
    cycle(0, 8'h00, 0, 0, 1);
    chk("t5.cleared", 32'(underflow_err), 0);

    // Fill to capacity, then consume, then flush with consume
    for (int k = 0; k < 12; k++) begin
      if (!byte_ready) break;
      cycle(1, 8'h5A, 0, 0, 0);
    end
    chk("t6.bit_count_full", 32'(bit_count), 64);
    chk("t6.byte_ready_full", 32'(byte_ready), 0);
    cycle(1, 8'h5A, 1, 8, 0);
    chk("t6.bit_count_56", 32'(bit_count), 56);
    chk("t6.byte_ready_56", 32'(byte_ready), 1);
    cycle(1, 8'h5A, 1, 8, 1);
    chk_reset_vals("t6.flush");

    // Randomized traffic with FF/00-heavy bytes, occasional flush and one mid-run reset
    for (int n = 0; n < 4000; n++) begin
      int r;
      logic [7:0] b;
      r = $urandom_range(0, 99);
      b = (r < 12) ? 8'hFF : (r < 24) ? 8'h00 : 8'($urandom);
      if (n == 2000) reset_n = 1'b0;
      if (n == 2001) reset_n = 1'b1;
      cycle(1'($urandom_range(0, 1)), b, 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 16)), ($urandom_range(0, 39) == 0));
    end
    cycle(0, 8'h00, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
